// File: rtl/dd_n_way.sv
// dd_n_way: radix demultiplexer stage of the partitioned hash join.
// NUM_IN independent input streams are routed to 2**RADIX_BITS outputs by a
// field of the hash digest. Each output owns a round-robin arbiter and a small
// FIFO, so a stalled output only ever blocks the inputs that target it.
module dd_n_way #(
   parameter int unsigned INPUT_SIZE   = 64,
   parameter int unsigned TAG_WIDTH    = 32,
   parameter int unsigned NUM_IN       = 2,
   parameter int unsigned RADIX_BITS   = 1,
   parameter int unsigned DECISION_LSB = 0,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                                               clk,
   input  logic                                               resetn,
   input  logic [NUM_IN*INPUT_SIZE-1:0]                       in_data,
   input  logic [NUM_IN*TAG_WIDTH-1:0]                        in_tag,
   input  logic [NUM_IN-1:0]                                  in_valid,
   output logic [NUM_IN-1:0]                                  in_ready,
   output logic [(2**RADIX_BITS)*INPUT_SIZE-1:0]              out_data,
   output logic [(2**RADIX_BITS)*TAG_WIDTH-1:0]               out_tag,
   output logic [(2**RADIX_BITS)-1:0]                         out_valid,
   input  logic [(2**RADIX_BITS)-1:0]                         out_ready,
   output logic [(2**RADIX_BITS)*$clog2(FIFO_DEPTH+1)-1:0]    out_count
);

   localparam int unsigned NUM_OUT = 2 ** RADIX_BITS;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   // Per-output FIFO storage and bookkeeping
   logic [INPUT_SIZE-1:0] r_mem_data [NUM_OUT][FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]  r_mem_tag  [NUM_OUT][FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wptr     [NUM_OUT];
   logic [PTR_W-1:0]      r_rptr     [NUM_OUT];
   logic [CNT_W-1:0]      r_count    [NUM_OUT];
   // Round-robin pointer per output: the input index searched first
   logic [SEL_W-1:0]      r_rr       [NUM_OUT];

   logic [RADIX_BITS-1:0] w_dest      [NUM_IN];
   logic [SEL_W-1:0]      w_win       [NUM_OUT];
   logic [SEL_W-1:0]      w_rr_next   [NUM_OUT];
   logic [INPUT_SIZE-1:0] w_push_data [NUM_OUT];
   logic [TAG_WIDTH-1:0]  w_push_tag  [NUM_OUT];
   logic [NUM_IN-1:0]     w_grant;
   logic [NUM_OUT-1:0]    w_push;
   logic [NUM_OUT-1:0]    w_pop;
   logic [NUM_OUT-1:0]    w_full;
   logic [NUM_OUT-1:0]    w_nonempty;

   // Extract the destination field of every input tuple
   always_comb begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         w_dest[i] = in_data[i*INPUT_SIZE + DECISION_LSB +: RADIX_BITS];
      end
   end

   // FIFO status flags; readiness looks at the full flag only, never at a pop
   always_comb begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         w_full[j]     = (r_count[j] == CNT_W'(FIFO_DEPTH));
         w_nonempty[j] = (r_count[j] != '0);
         w_pop[j]      = w_nonempty[j] & out_ready[j];
      end
   end

   // Per-output round-robin arbitration over the inputs that target it
   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_grant = '0;
      w_push  = '0;
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         w_win[j]     = '0;
         w_rr_next[j] = r_rr[j];
      end
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = 32'(r_rr[j]) + k;
            if (idx >= NUM_IN) begin
               idx = idx - NUM_IN;
            end
            if (!w_full[j] && !w_push[j] && in_valid[idx] &&
                (w_dest[idx] == RADIX_BITS'(j))) begin
               w_push[j]    = 1'b1;
               w_win[j]     = SEL_W'(idx);
               w_grant[idx] = 1'b1;
               w_rr_next[j] = (idx == NUM_IN - 1) ? '0 : SEL_W'(idx + 1);
            end
         end
      end
   end

   // Select the winning tuple for each output's push port
   always_comb begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         w_push_data[j] = in_data[32'(w_win[j])*INPUT_SIZE +: INPUT_SIZE];
         w_push_tag[j]  = in_tag[32'(w_win[j])*TAG_WIDTH +: TAG_WIDTH];
      end
   end

   // Handshake back to the inputs; held low while reset is asserted
   always_comb begin
      in_ready = resetn ? '0 : w_grant;
   end

   // FIFO payload storage; contents need no reset because the head is gated by valid
   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         if (!resetn && w_push[j]) begin
            r_mem_data[j][r_wptr[j]] <= w_push_data[j];
            r_mem_tag[j][r_wptr[j]]  <= w_push_tag[j];
         end
      end
   end

   // FIFO pointers, occupancy and arbiter pointers
   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         if (resetn) begin
            r_wptr[j]  <= '0;
            r_rptr[j]  <= '0;
            r_count[j] <= '0;
            r_rr[j]    <= '0;
         end else begin
            if (w_push[j]) begin
               r_wptr[j] <= r_wptr[j] + PTR_W'(1);
            end
            if (w_pop[j]) begin
               r_rptr[j] <= r_rptr[j] + PTR_W'(1);
            end
            case ({w_push[j], w_pop[j]})
               2'b10:   r_count[j] <= r_count[j] + CNT_W'(1);
               2'b01:   r_count[j] <= r_count[j] - CNT_W'(1);
               default: r_count[j] <= r_count[j];
            endcase
            r_rr[j] <= w_rr_next[j];
         end
      end
   end

   // Present FIFO heads; data and tag read as zero while the FIFO is empty
   always_comb begin
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         out_valid[j]                          = w_nonempty[j];
         out_data[j*INPUT_SIZE +: INPUT_SIZE]  = w_nonempty[j] ? r_mem_data[j][r_rptr[j]] : '0;
         out_tag[j*TAG_WIDTH +: TAG_WIDTH]     = w_nonempty[j] ? r_mem_tag[j][r_rptr[j]] : '0;
         out_count[j*CNT_W +: CNT_W]           = r_count[j];
      end
   end

endmodule

// File: tb/tb_dd_n_way.sv
// tb_dd_n_way: directed and randomized bench for dd_n_way with a queue-based
// reference model (one queue per output, round-robin pointer per output).
module tb_dd_n_way;

   localparam int NI    = 2;
   localparam int RB    = 2;
   localparam int NO    = 4;
   localparam int DEPTH = 4;
   localparam int IS    = 64;
   localparam int TW    = 32;
   localparam int CW    = 3;

   logic                clk = 1'b0;
   logic                resetn;
   logic [NI*IS-1:0]    in_data;
   logic [NI*TW-1:0]    in_tag;
   logic [NI-1:0]       in_valid;
   logic [NI-1:0]       in_ready;
   logic [NO*IS-1:0]    out_data;
   logic [NO*TW-1:0]    out_tag;
   logic [NO-1:0]       out_valid;
   logic [NO-1:0]       out_ready;
   logic [NO*CW-1:0]    out_count;

   dd_n_way #(
      .INPUT_SIZE   (IS),
      .TAG_WIDTH    (TW),
      .NUM_IN       (NI),
      .RADIX_BITS   (RB),
      .DECISION_LSB (0),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: each output is a queue of {data, tag}; rr is the next input to favour
   logic [IS+TW-1:0] mq [NO][$];
   int               mrr [NO];
   logic             chk_en = 1'b0;
   logic             ord_en = 1'b0;

   function automatic int dest_of(input int i);
      logic [IS-1:0] d;
      d = in_data[i*IS +: IS];
      return int'(d[RB-1:0]);
   endfunction

   // Which inputs the specification says must be accepted right now
   function automatic logic [NI-1:0] model_ready();
      logic [NI-1:0] r;
      logic          found;
      int            i;
      r = '0;
      if (resetn) return r;
      for (int j = 0; j < NO; j++) begin
         found = 1'b0;
         if (mq[j].size() < DEPTH) begin
            for (int off = 0; off < NI; off++) begin
               i = (mrr[j] + off) % NI;
               if (!found && in_valid[i] && dest_of(i) == j) begin
                  r[i]  = 1'b1;
                  found = 1'b1;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic model_empty();
      for (int j = 0; j < NO; j++) if (mq[j].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Model update at each active edge
   always @(posedge clk) begin
      logic [NI-1:0] g;
      g = model_ready();
      if (resetn) begin
         for (int j = 0; j < NO; j++) begin
            mq[j].delete();
            mrr[j] <= 0;
         end
      end else begin
         for (int j = 0; j < NO; j++) begin
            if (mq[j].size() > 0 && out_ready[j]) void'(mq[j].pop_front());
         end
         for (int i = 0; i < NI; i++) begin
            if (g[i]) begin
               mq[dest_of(i)].push_back({in_data[i*IS +: IS], in_tag[i*TW +: TW]});
               mrr[dest_of(i)] <= (i + 1) % NI;
            end
         end
      end
   end

   // DUT-observed handshakes, used by the stimulus and for conservation
   logic [NI-1:0] acc_q = '0;
   int            n_acc = 0;
   int            n_pop = 0;
   always @(posedge clk) begin
      acc_q <= in_valid & in_ready;
      if (ord_en) begin
         n_acc <= n_acc + $countones(in_valid & in_ready);
         n_pop <= n_pop + $countones(out_valid & out_ready);
      end
   end

   // Compare process: DUT outputs against the model every cycle, mid-period
   int last_seq [NI][NO];
   always @(negedge clk) begin
      logic [IS+TW-1:0] e;
      logic [IS-1:0]    d;
      logic             ev;
      int               src;
      int               sq;
      if (chk_en) begin
         chk("in_ready", 128'(in_ready), 128'(model_ready()));
         for (int j = 0; j < NO; j++) begin
            ev = (mq[j].size() > 0);
            e  = ev ? mq[j][0] : '0;
            chk("out_valid", 128'(out_valid[j]), 128'(ev));
            chk("out_count", 128'(out_count[j*CW +: CW]), 128'(mq[j].size()));
            chk("out_data", 128'(out_data[j*IS +: IS]), 128'(e[IS+TW-1:TW]));
            chk("out_tag", 128'(out_tag[j*TW +: TW]), 128'(e[TW-1:0]));
         end
      end
      if (ord_en) begin
         for (int j = 0; j < NO; j++) begin
            if (out_valid[j] && out_ready[j]) begin
               d   = out_data[j*IS +: IS];
               src = int'(d[63:56]);
               sq  = int'(d[55:32]);
               chk("route", 128'(d[1:0]), 128'(j));
               chk("src_range", 128'(src < NI), 128'(1));
               if (src < NI) begin
                  chk("per_input_order", 128'(sq > last_seq[src][j]), 128'(1));
                  last_seq[src][j] = sq;
               end
            end
         end
      end
   end

   // Stimulus state
   logic [IS-1:0] cd  [NI];
   logic [TW-1:0] ct  [NI];
   logic          cv  [NI];
   int            seq [NI];

   task automatic drive();
      for (int i = 0; i < NI; i++) begin
         in_data[i*IS +: IS] = cd[i];
         in_tag[i*TW +: TW]  = ct[i];
         in_valid[i]         = cv[i];
      end
   endtask

   task automatic make_tuple(input int i, input int d);
      seq[i]++;
      cd[i] = {8'(i), 24'(seq[i]), 30'($urandom), 2'(d)};
      ct[i] = $urandom;
      cv[i] = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [IS-1:0] first_d;
      int            acc;
      int            sent;
      int            guard;
      int            phase;
      for (int i = 0; i < NI; i++) begin
         cd[i]  = '0;
         ct[i]  = '0;
         cv[i]  = 1'b0;
         seq[i] = 0;
      end
      resetn    = 1'b1;
      out_ready = '1;
      make_tuple(0, 1);
      make_tuple(1, 2);
      drive();
      tick();
      tick();
      chk_en = 1'b1;

      // Reset state, with valid inputs that must still see in_ready low
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_count", 128'(out_count), 128'(0));
      chk("rst_out_data", 128'(out_data[IS +: IS]), 128'(0));
      tick();
      resetn = 1'b0;

      // Two inputs to two different outputs in one cycle
      cd[0] = 64'hA0A0_0000_0000_0001; ct[0] = 32'h1111_0001; cv[0] = 1'b1;
      cd[1] = 64'hB0B0_0000_0000_0002; ct[1] = 32'h2222_0002; cv[1] = 1'b1;
      drive();
      @(negedge clk);
      chk("t1_both_ready", 128'(in_ready), 128'(2'b11));
      tick();
      cv[0] = 1'b0;
      cv[1] = 1'b0;
      drive();
      @(negedge clk);
      chk("t1_out_valid", 128'(out_valid), 128'(4'b0110));
      chk("t1_out1_data", 128'(out_data[1*IS +: IS]), 128'(64'hA0A0_0000_0000_0001));
      chk("t1_out1_tag", 128'(out_tag[1*TW +: TW]), 128'(32'h1111_0001));
      chk("t1_out2_data", 128'(out_data[2*IS +: IS]), 128'(64'hB0B0_0000_0000_0002));
      chk("t1_out2_tag", 128'(out_tag[2*TW +: TW]), 128'(32'h2222_0002));

      // Both inputs contend for output 3: grants alternate starting at input 0
      tick();
      make_tuple(0, 3);
      make_tuple(1, 3);
      drive();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_alternate", 128'(in_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
         tick();
         for (int i = 0; i < NI; i++) if (acc_q[i]) make_tuple(i, 3);
         drive();
      end
      cv[0] = 1'b0;
      cv[1] = 1'b0;
      drive();
      tick();
      tick();

      // Output 1 stalled: 6 tuples offered, only 4 fit
      out_ready = 4'b1101;
      make_tuple(0, 1);
      first_d = cd[0];
      drive();
      sent = 1;
      acc  = 0;
      repeat (6) begin
         tick();
         if (acc_q[0]) begin
            acc++;
            if (sent < 6) begin
               make_tuple(0, 1);
               sent++;
            end else begin
               cv[0] = 1'b0;
            end
         end
         drive();
      end
      @(negedge clk);
      chk("t3_accepted_4", 128'(acc), 128'(4));
      chk("t3_blocked", 128'(in_ready[0]), 128'(0));
      chk("t3_count_full", 128'(out_count[1*CW +: CW]), 128'(4));
      chk("t3_head_first", 128'(out_data[1*IS +: IS]), 128'(first_d));
      tick();
      out_ready = 4'b1111;
      drive();
      @(negedge clk);
      chk("t3_still_full", 128'(in_ready[0]), 128'(0));
      tick();
      @(negedge clk);
      chk("t3_ready_after_pop", 128'(in_ready[0]), 128'(1));
      guard = 0;
      while (acc < 6 && guard < 20) begin
         tick();
         guard++;
         if (acc_q[0]) begin
            acc++;
            if (sent < 6) begin
               make_tuple(0, 1);
               sent++;
            end else begin
               cv[0] = 1'b0;
            end
         end
         drive();
      end
      chk("t3_all_accepted", 128'(acc), 128'(6));

      // Output 0 full and stalled must not slow input 1 streaming to output 2
      out_ready = 4'b1110;
      make_tuple(0, 0);
      make_tuple(1, 2);
      drive();
      acc = 0;
      repeat (10) begin
         tick();
         if (acc_q[0]) make_tuple(0, 0);
         if (acc_q[1]) begin
            acc++;
            make_tuple(1, 2);
         end
         drive();
      end
      chk("t4_in1_full_rate", 128'(acc), 128'(10));
      @(negedge clk);
      chk("t4_out0_full", 128'(out_count[0*CW +: CW]), 128'(4));
      chk("t4_in0_blocked", 128'(in_ready[0]), 128'(0));

      // Drain, then buffer 3 tuples and reset mid-operation
      tick();
      cv[0] = 1'b0;
      cv[1] = 1'b0;
      out_ready = 4'b1111;
      drive();
      guard = 0;
      while (!model_empty() && guard < 40) begin
         tick();
         guard++;
      end
      chk("t5_drained", 128'(model_empty()), 128'(1));
      out_ready = 4'b0000;
      make_tuple(0, 1);
      drive();
      acc   = 0;
      guard = 0;
      while (acc < 3 && guard < 10) begin
         tick();
         guard++;
         if (acc_q[0]) begin
            acc++;
            if (acc < 3) make_tuple(0, 1);
            else cv[0] = 1'b0;
         end
         drive();
      end
      @(negedge clk);
      chk("t5_buffered_3", 128'(out_count[1*CW +: CW]), 128'(3));
      tick();
      resetn = 1'b1;
      make_tuple(0, 2);
      drive();
      @(negedge clk);
      chk("t5_ready_in_reset", 128'(in_ready), 128'(0));
      tick();
      resetn = 1'b0;
      make_tuple(0, 1);
      make_tuple(1, 1);
      drive();
      @(negedge clk);
      chk("t5_valid_cleared", 128'(out_valid), 128'(0));
      chk("t5_count_cleared", 128'(out_count), 128'(0));
      chk("t5_first_grant_in0", 128'(in_ready), 128'(2'b01));
      tick();
      out_ready = 4'b1111;
      cv[0] = 1'b0;
      cv[1] = 1'b0;
      drive();
      guard = 0;
      while (!model_empty() && guard < 40) begin
         tick();
         guard++;
      end

      // Randomized traffic and backpressure
      for (int i = 0; i < NI; i++) for (int j = 0; j < NO; j++) last_seq[i][j] = -1;
      ord_en = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         tick();
         phase = (c / 500) % 3;
         for (int i = 0; i < NI; i++) begin
            if (acc_q[i]) cv[i] = 1'b0;
            if (!cv[i] && $urandom_range(0, 9) < 7) make_tuple(i, $urandom_range(0, NO - 1));
         end
         for (int j = 0; j < NO; j++) begin
            case (phase)
               0:       out_ready[j] = ($urandom_range(0, 9) < 9);
               1:       out_ready[j] = ($urandom_range(0, 9) < 5);
               default: out_ready[j] = ($urandom_range(0, 9) < 1);
            endcase
         end
         drive();
      end
      tick();
      for (int i = 0; i < NI; i++) cv[i] = 1'b0;
      out_ready = 4'b1111;
      drive();
      guard = 0;
      while ((!model_empty() || out_valid != '0) && guard < 40) begin
         tick();
         guard++;
      end
      tick();
      chk("final_drained", 128'(out_valid), 128'(0));
      chk("conservation", 128'(n_pop), 128'(n_acc));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
